// File: rtl/draw_sequencer.sv
// -----------------------------------------------------------------------------
// draw_sequencer
//
// Top-level drawing controller that sits between the VGA adapter and two
// drawing engines. On a run request it starts the screen-clear engine
// (fillscreen), waits one idle cycle, then starts the shape engine. Only the
// engine that owns the current phase has its plot stream sampled. That stream
// is clipped to the visible screen, registered once, and driven onto the single
// VGA plot port. Forwarded plots are counted per run, saturating at 32767.
//
// Parameters
//   SCREEN_W   visible width; a plot is forwarded only if x < SCREEN_W
//   SCREEN_H   visible height; a plot is forwarded only if y < SCREEN_H
//   CLEAR_EN   1 = clear engine runs before the shape engine, 0 = shape only
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   start / done                    level run request / run complete
//   bg_colour, fg_colour            colours passed through to the engines
//   fs_start, fs_colour             clear engine start and colour
//   fs_done, fs_x/y/col/plot        clear engine done and plot stream
//   dr_start, dr_colour             shape engine start and colour
//   dr_done, dr_x/y/col/plot        shape engine done and plot stream
//   vga_x/y/colour/plot             registered plot to the VGA adapter
//   plot_count                      plots forwarded in the current run
// -----------------------------------------------------------------------------
module draw_sequencer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    input  logic [2:0]  bg_colour,
    input  logic [2:0]  fg_colour,
    output logic        fs_start,
    output logic [2:0]  fs_colour,
    input  logic        fs_done,
    input  logic [7:0]  fs_x,
    input  logic [6:0]  fs_y,
    input  logic [2:0]  fs_col,
    input  logic        fs_plot,
    output logic        dr_start,
    output logic [2:0]  dr_colour,
    input  logic        dr_done,
    input  logic [7:0]  dr_x,
    input  logic [6:0]  dr_y,
    input  logic [2:0]  dr_col,
    input  logic        dr_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [14:0] plot_count
);

    // One bit wider than the coordinates so a limit equal to 2^N still compares.
    localparam logic [8:0]  X_LIM   = 9'(SCREEN_W);
    localparam logic [7:0]  Y_LIM   = 8'(SCREEN_H);
    localparam logic [14:0] CNT_MAX = 15'h7FFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GAP,
        S_DRAW,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        clr_cnt;

    logic        src_plot;
    logic [7:0]  src_x;
    logic [6:0]  src_y;
    logic [2:0]  src_col;
    logic        fwd;

    logic [7:0]  vga_x_q, vga_x_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic [2:0]  vga_col_q, vga_col_d;
    logic        vga_plot_q, vga_plot_d;
    logic [14:0] plot_count_q, plot_count_d;

    // Next-state logic. Dropping start aborts from any working phase; the
    // abort takes priority over a coincident engine done.
    always_comb begin
        state_d = state_q;
        clr_cnt = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr_cnt = 1'b1;
                    if (CLEAR_EN) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DRAW;
                    end
                end
            end
            S_CLEAR: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (fs_done) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (dr_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Source select: only the engine owning the phase is looked at, so the
    // idle engine's stray plots can never leak through.
    always_comb begin
        src_plot = 1'b0;
        src_x    = fs_x;
        src_y    = fs_y;
        src_col  = fs_col;
        if (state_q == S_CLEAR) begin
            src_plot = fs_plot;
        end else if (state_q == S_DRAW) begin
            src_plot = dr_plot;
            src_x    = dr_x;
            src_y    = dr_y;
            src_col  = dr_col;
        end
    end

    assign fwd = src_plot && ({1'b0, src_x} < X_LIM) && ({1'b0, src_y} < Y_LIM);

    always_comb begin
        vga_plot_d = fwd;
        vga_x_d    = vga_x_q;
        vga_y_d    = vga_y_q;
        vga_col_d  = vga_col_q;
        if (fwd) begin
            vga_x_d   = src_x;
            vga_y_d   = src_y;
            vga_col_d = src_col;
        end
    end

    always_comb begin
        plot_count_d = plot_count_q;
        if (clr_cnt) begin
            plot_count_d = '0;
        end else if (fwd && (plot_count_q != CNT_MAX)) begin
            plot_count_d = plot_count_q + 15'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vga_plot_q   <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_col_q    <= '0;
            plot_count_q <= '0;
        end else begin
            state_q      <= state_d;
            vga_plot_q   <= vga_plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_col_q    <= vga_col_d;
            plot_count_q <= plot_count_d;
        end
    end

    // Handshake outputs are pure decodes of the state register, so no input
    // reaches them combinationally.
    assign fs_start   = (state_q == S_CLEAR);
    assign dr_start   = (state_q == S_DRAW);
    assign done       = (state_q == S_DONE);

    assign fs_colour  = bg_colour;
    assign dr_colour  = fg_colour;

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;
    assign vga_plot   = vga_plot_q;
    assign plot_count = plot_count_q;

endmodule
